// File: rtl/mw93_responder.sv
// Device side of a 93C46-style Microwire EEPROM, x16 organisation.
// Optional macro MW93_SEQ_READ_EN: sequential read continues at addr+1 after each word.
module mw93_responder #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BUSY_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sk,
  input  logic di,
  output logic do_o,
  output logic do_oe,
  output logic busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned BSY_W = $clog2(BUSY_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_RDATA, S_WDATA, S_WAIT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_WRITE, C_ERASE, C_WRAL, C_ERAL
  } cmd_t;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                ewen_q, ewen_d;
  logic                sk_q;
  logic                do_o_q, do_o_d;
  logic                do_oe_q, do_oe_d;
  logic                busy_q, busy_d;
  logic [BSY_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                sk_rise;
  logic [ADDR_W-1:0]   addr_full;

  assign sk_rise   = cs & sk & ~sk_q;
  assign addr_full = {addr_q[ADDR_W-2:0], di};

  // Protocol decode, memory commit and programming timer.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ewen_d  = ewen_q;
    do_o_d  = do_o_q;
    do_oe_d = do_oe_q;
    busy_d  = busy_q;
    bcnt_d  = bcnt_q;
    mem_d   = mem_q;

    if (busy_q) begin
      if (bcnt_q == '0) busy_d = 1'b0;
      else              bcnt_d = bcnt_q - BSY_W'(1);
    end

    if (!cs) begin
      state_d = S_IDLE;
      do_oe_d = 1'b0;
      cmd_d   = C_NONE;
      // A deselect in WAIT is the only point where a write-class command lands.
      if (state_q == S_WAIT && ewen_q && cmd_q != C_NONE) begin
        case (cmd_q)
          C_WRITE: mem_d[addr_q] = sh_q;
          C_ERASE: mem_d[addr_q] = '1;
          C_WRAL:  for (int unsigned i = 0; i < DEPTH; i++) mem_d[ADDR_W'(i)] = sh_q;
          C_ERAL:  for (int unsigned i = 0; i < DEPTH; i++) mem_d[ADDR_W'(i)] = '1;
          default: ;
        endcase
        busy_d = 1'b1;
        bcnt_d = BSY_W'(BUSY_CYCLES - 1);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sk_rise && di && !busy_q) begin
            state_d = S_OPC;
            cnt_d   = '0;
            cmd_d   = C_NONE;
            do_oe_d = 1'b0;
          end else begin
            do_oe_d = 1'b1;
            do_o_d  = ~busy_q;
          end
        end
        S_OPC: begin
          if (sk_rise) begin
            op_d  = {op_q[0], di};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_ADDR;
              cnt_d   = '0;
            end
          end
        end
        S_ADDR: begin
          if (sk_rise) begin
            addr_d = addr_full;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d   = '0;
              state_d = S_WAIT;
              case (op_q)
                2'b10: begin
                  state_d = S_RDATA;
                  do_oe_d = 1'b1;
                  do_o_d  = 1'b0;
                  sh_d    = mem_q[addr_full];
                end
                2'b01: begin
                  state_d = S_WDATA;
                  cmd_d   = C_WRITE;
                end
                2'b11: cmd_d = C_ERASE;
                default: begin
                  case (addr_full[ADDR_W-1 -: 2])
                    2'b11: ewen_d = 1'b1;
                    2'b00: ewen_d = 1'b0;
                    2'b01: begin
                      state_d = S_WDATA;
                      cmd_d   = C_WRAL;
                    end
                    default: cmd_d = C_ERAL;
                  endcase
                end
              endcase
            end
          end
        end
        S_RDATA: begin
          if (sk_rise) begin
            if (cnt_q < CNT_W'(DATA_W)) begin
              do_o_d = sh_q[DATA_W-1];
              sh_d   = {sh_q[DATA_W-2:0], 1'b0};
              cnt_d  = cnt_q + CNT_W'(1);
            end
`ifdef MW93_SEQ_READ_EN
            else begin
              addr_d = addr_q + ADDR_W'(1);
              do_o_d = mem_q[addr_q + ADDR_W'(1)][DATA_W-1];
              sh_d   = {mem_q[addr_q + ADDR_W'(1)][DATA_W-2:0], 1'b0};
              cnt_d  = CNT_W'(1);
            end
`endif
          end
        end
        S_WDATA: begin
          if (sk_rise) begin
            sh_d  = {sh_q[DATA_W-2:0], di};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= C_NONE;
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      ewen_q  <= 1'b0;
      sk_q    <= 1'b0;
      do_o_q  <= 1'b0;
      do_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      bcnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ewen_q  <= ewen_d;
      sk_q    <= sk;
      do_o_q  <= do_o_d;
      do_oe_q <= do_oe_d;
      busy_q  <= busy_d;
      bcnt_q  <= bcnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign do_o  = do_o_q;
  assign do_oe = do_oe_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mw93_responder.sv
// Randomized self-checking bench for mw93_responder against a word-array EEPROM model.
module tb_mw93_responder;

  logic clk = 1'b0;
  logic rst, cs, sk, di;
  logic do_o, do_oe, busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mem [64];
  logic        m_ewen;

  mw93_responder dut (
    .clk(clk), .rst(rst), .cs(cs), .sk(sk), .di(di),
    .do_o(do_o), .do_oe(do_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 16'hFFFF;
    m_ewen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; sk = 1'b0; di = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  // One SK period: low 2 clk, high 2 clk; DO sampled at the end of the high phase.
  task automatic sk_bit(input logic b, output logic o);
    di = b; sk = 1'b0;
    tick(); tick();
    sk = 1'b1;
    tick(); tick();
    o = do_o;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic o;
    for (int i = n - 1; i >= 0; i--) sk_bit(v[i], o);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [5:0] a);
    logic o;
    cs = 1'b1; sk = 1'b0;
    tick();
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) sk_bit(1'b0, o);
    sk_bit(1'b1, o);
    send_bits({14'd0, op}, 2);
    send_bits({10'd0, a}, 6);
  endtask

  // Deselect and measure how long busy stays high afterwards.
  task automatic end_and_busy(input logic commit, input string tag);
    int n = 0;
    sk = 1'b0; cs = 1'b0;
    tick();
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), commit ? 32'd64 : 32'd0);
  endtask

  function automatic logic exp_bit(input logic [5:0] a, input int i);
    int w = i / 16;
    int b = 15 - (i % 16);
`ifdef MW93_SEQ_READ_EN
    return m_mem[6'(int'(a) + w)][b];
`else
    if (i < 16) return m_mem[a][b];
    return m_mem[a][0];
`endif
  endfunction

  task automatic do_read(input logic [5:0] a, input int nbits, input string tag);
    logic [31:0] got = '0, exp = '0;
    logic o;
    start_cmd(2'b10, a);
    chk({tag, "_dummy_oe"}, 32'(do_oe), 32'd1);
    chk({tag, "_dummy"}, 32'(do_o), 32'd0);
    for (int i = 0; i < nbits; i++) begin
      sk_bit(1'b0, o);
      got = {got[30:0], o};
      exp = {exp[30:0], exp_bit(a, i)};
    end
    if (nbits > 16) begin
      chk({tag, "_w0"}, 32'(got[31:16]), 32'(exp[31:16]));
      chk({tag, "_w1"}, 32'(got[15:0]), 32'(exp[15:0]));
    end else begin
      chk(tag, 32'(got[15:0]), 32'(exp[15:0]));
    end
    sk = 1'b0; cs = 1'b0;
    tick();
    chk({tag, "_oe_off"}, 32'(do_oe), 32'd0);
    tick();
  endtask

  task automatic do_ew(input logic en);
    start_cmd(2'b00, {en, en, 4'($urandom)});
    end_and_busy(1'b0, en ? "ewen_busy" : "ewds_busy");
    m_ewen = en;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    start_cmd(2'b01, a);
    send_bits(d, 16);
    end_and_busy(m_ewen, "write_busy");
    if (m_ewen) m_mem[a] = d;
    tick();
  endtask

  task automatic do_erase(input logic [5:0] a);
    start_cmd(2'b11, a);
    end_and_busy(m_ewen, "erase_busy");
    if (m_ewen) m_mem[a] = 16'hFFFF;
    tick();
  endtask

  task automatic do_wral(input logic [15:0] d);
    start_cmd(2'b00, {2'b01, 4'($urandom)});
    send_bits(d, 16);
    end_and_busy(m_ewen, "wral_busy");
    if (m_ewen) for (int i = 0; i < 64; i++) m_mem[i] = d;
    tick();
  endtask

  task automatic do_eral();
    start_cmd(2'b00, {2'b10, 4'($urandom)});
    end_and_busy(m_ewen, "eral_busy");
    if (m_ewen) for (int i = 0; i < 64; i++) m_mem[i] = 16'hFFFF;
    tick();
  endtask

  task automatic do_abort_write(input logic [5:0] a, input int nb);
    start_cmd(2'b01, a);
    send_bits(16'($urandom), nb);
    end_and_busy(1'b0, "abort_busy");
    tick();
  endtask

  // Write with cs raised again during the programming time to poll status.
  task automatic do_write_poll(input logic [5:0] a, input logic [15:0] d);
    logic o;
    int n = 0;
    start_cmd(2'b01, a);
    send_bits(d, 16);
    sk = 1'b0; cs = 1'b0;
    tick();
    m_mem[a] = d;
    cs = 1'b1;
    tick(); tick(); tick();
    chk("poll_busy_oe", 32'(do_oe), 32'd1);
    chk("poll_busy", 32'(do_o), 32'd0);
    sk_bit(1'b1, o);
    chk("busy_start_ignored_oe", 32'(do_oe), 32'd1);
    chk("busy_start_ignored", 32'(o), 32'd0);
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk("poll_busy_ended", 32'(busy), 32'd0);
    tick(); tick();
    chk("poll_ready", 32'(do_o), 32'd1);
    sk = 1'b0; cs = 1'b0;
    tick(); tick();
  endtask

  initial begin
    do_reset();
    chk("rst_do", 32'(do_o), 32'd0);
    chk("rst_oe", 32'(do_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    do_read(6'd5, 16, "read_erased");
    do_ew(1'b1);
    do_write(6'd3, 16'hA55A);
    do_read(6'd3, 16, "read_a55a");
    do_ew(1'b0);
    do_write(6'd3, 16'h1234);
    do_read(6'd3, 16, "read_protected");
    do_ew(1'b1);
    do_abort_write(6'd3, 8);
    do_read(6'd3, 16, "read_after_abort");
    do_write_poll(6'd7, 16'h5AA5);
    do_read(6'd7, 16, "read_polled");
    do_wral(16'h0F0F);
    do_erase(6'd63);
    do_read(6'd0, 16, "read_wral");
    do_read(6'd63, 16, "read_erase63");
    do_write(6'd63, 16'hC3A1);
    do_write(6'd0, 16'h7E81);
    do_read(6'd63, 32, "read_wrap");

    // Reset during programming restores the erased array and clears ewen.
    start_cmd(2'b01, 6'd10);
    send_bits(16'h0000, 16);
    sk = 1'b0; cs = 1'b0;
    tick(); tick(); tick();
    do_reset();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    do_read(6'd10, 16, "read_after_rst");
    do_write(6'd10, 16'h0000);
    do_read(6'd10, 16, "read_rst_ewds");

    for (int it = 0; it < 40; it++) begin
      int r = int'($urandom_range(0, 10));
      logic [5:0] a = 6'($urandom);
      logic [15:0] d = 16'($urandom);
      case (r)
        0, 1, 2: do_read(a, ($urandom_range(0, 1) == 1) ? 32 : 16, "rand_read");
        3, 4:    do_write(a, d);
        5:       do_erase(a);
        6, 7:    do_ew(1'b1);
        8:       do_ew(1'b0);
        9:       do_abort_write(a, int'($urandom_range(1, 15)));
        default: begin
          if ($urandom_range(0, 1) == 1) do_wral(d);
          else                           do_eral();
        end
      endcase
    end
    for (int i = 0; i < 4; i++) do_read(6'($urandom), 32, "final_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
